// File: rtl/rgb_frame_reader.sv
`default_nettype none
// ============================================================================
// rgb_frame_reader: raster readback of G/R/B planes into a packed RGB stream.
// Optional: CFA_READER_CLIP_EN adds clipMax channel saturation.    Rev 1.0
// ============================================================================
module rgb_frame_reader #(
   parameter int addressBitWidth = 17,
   parameter int rowBitWidth     = 11,
   parameter int colBitWidth     = 11,
   parameter int dataBitWidth    = 12
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic signed [rowBitWidth-1:0] rowMax,
   input  logic signed [colBitWidth-1:0] colMax,
`ifdef CFA_READER_CLIP_EN
   input  logic [dataBitWidth-1:0]       clipMax,
`endif
   output logic [addressBitWidth-1:0]    readAddress,
   output logic                          readEnable,
   input  logic [dataBitWidth-1:0]       greenRead,
   input  logic [dataBitWidth-1:0]       redRead,
   input  logic [dataBitWidth-1:0]       blueRead,
   output logic [3*dataBitWidth-1:0]     pixelOut,
   output logic                          pixelValid,
   input  logic                          pixelReady,
   output logic                          sof,
   output logic                          eol,
   output logic                          eof,
   output logic                          busy,
   output logic                          done
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_DRAIN  = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   localparam int EW = 3*dataBitWidth + 3;

   state_t                     state_q, state_d;
   logic [rowBitWidth-1:0]     row_q, row_d, row_max_q, row_max_d;
   logic [colBitWidth-1:0]     col_q, col_d, col_max_q, col_max_d;
   logic [addressBitWidth-1:0] addr_q, addr_d;
   logic                       infl_q, infl_d;
   logic [2:0]                 infl_mark_q, infl_mark_d;
   logic [EW-1:0]              fifo_q [2];
   logic [EW-1:0]              fifo_d [2];
   logic                       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [1:0]                 count_q, count_d;
   logic                       pop;
   logic [2:0]                 outstanding;
   logic [dataBitWidth-1:0]    red_c, green_c, blue_c;

`ifdef CFA_READER_CLIP_EN
   logic [dataBitWidth-1:0]    clip_q, clip_d;

   always_comb begin
      red_c   = (redRead   > clip_q) ? clip_q : redRead;
      green_c = (greenRead > clip_q) ? clip_q : greenRead;
      blue_c  = (blueRead  > clip_q) ? clip_q : blueRead;
   end
`else
   always_comb begin
      red_c   = redRead;
      green_c = greenRead;
      blue_c  = blueRead;
   end
`endif

   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      col_d       = col_q;
      row_max_d   = row_max_q;
      col_max_d   = col_max_q;
      addr_d      = addr_q;
      infl_d      = 1'b0;
      infl_mark_d = infl_mark_q;
      fifo_d      = fifo_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      readEnable  = 1'b0;
`ifdef CFA_READER_CLIP_EN
      clip_d      = clip_q;
`endif
      pop         = (count_q != 2'd0) && pixelReady;
      // Credits count the pop of this cycle so a full-rate stream never stalls.
      outstanding = {1'b0, count_q} + {2'b00, infl_q} - {2'b00, pop};

      if (infl_q) begin
         fifo_d[wr_ptr_q] = {red_c, green_c, blue_c, infl_mark_q};
         wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, infl_q} - {1'b0, pop};

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (!rowMax[rowBitWidth-1] && !colMax[colBitWidth-1]) begin
                  state_d   = S_RUN;
                  row_max_d = $unsigned(rowMax);
                  col_max_d = $unsigned(colMax);
                  row_d     = '0;
                  col_d     = '0;
                  addr_d    = '0;
`ifdef CFA_READER_CLIP_EN
                  clip_d    = clipMax;
`endif
               end else begin
                  state_d = S_FINISH;
               end
            end
         end
         S_RUN: begin
            if (outstanding < 3'd2) begin
               readEnable  = 1'b1;
               infl_d      = 1'b1;
               infl_mark_d = {(row_q == '0) && (col_q == '0),
                              col_q == col_max_q,
                              (row_q == row_max_q) && (col_q == col_max_q)};
               addr_d      = addr_q + 1'b1;
               if (col_q == col_max_q) begin
                  col_d = '0;
                  row_d = row_q + 1'b1;
                  if (row_q == row_max_q) begin
                     state_d = S_DRAIN;
                  end
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         S_DRAIN: begin
            if (count_d == 2'd0) begin
               state_d = S_FINISH;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         row_q       <= '0;
         col_q       <= '0;
         row_max_q   <= '0;
         col_max_q   <= '0;
         addr_q      <= '0;
         infl_q      <= 1'b0;
         infl_mark_q <= '0;
         fifo_q[0]   <= '0;
         fifo_q[1]   <= '0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         count_q     <= '0;
`ifdef CFA_READER_CLIP_EN
         clip_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         col_q       <= col_d;
         row_max_q   <= row_max_d;
         col_max_q   <= col_max_d;
         addr_q      <= addr_d;
         infl_q      <= infl_d;
         infl_mark_q <= infl_mark_d;
         fifo_q      <= fifo_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
`ifdef CFA_READER_CLIP_EN
         clip_q      <= clip_d;
`endif
      end
   end

   assign readAddress                = addr_q;
   assign pixelValid                 = (count_q != 2'd0);
   assign {pixelOut, sof, eol, eof}  = fifo_q[rd_ptr_q];
   assign busy                       = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign done                       = (state_q == S_FINISH);

endmodule
`default_nettype wire

// File: tb/tb_rgb_frame_reader.sv
`default_nettype none
// ============================================================================
// tb_rgb_frame_reader: scoreboard bench, random frames, backpressure, resets.
// Rev 1.0
// ============================================================================
module tb_rgb_frame_reader;
   localparam int AW = 17;
   localparam int RW = 11;
   localparam int CW = 11;
   localparam int DW = 12;
   localparam int PW = 3*DW + 3;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 start = 1'b0;
   logic signed [RW-1:0] rowMax = '0;
   logic signed [CW-1:0] colMax = '0;
   logic [DW-1:0]        greenRead = '0, redRead = '0, blueRead = '0;
   logic                 pixelReady = 1'b1;
   logic [AW-1:0]        readAddress;
   logic                 readEnable;
   logic [3*DW-1:0]      pixelOut;
   logic                 pixelValid, sof, eol, eof, busy, done;
`ifdef CFA_READER_CLIP_EN
   logic [DW-1:0]        clipMax = '1;
`endif

   rgb_frame_reader #(
      .addressBitWidth(AW), .rowBitWidth(RW), .colBitWidth(CW), .dataBitWidth(DW)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .rowMax(rowMax), .colMax(colMax),
`ifdef CFA_READER_CLIP_EN
      .clipMax(clipMax),
`endif
      .readAddress(readAddress), .readEnable(readEnable),
      .greenRead(greenRead), .redRead(redRead), .blueRead(blueRead),
      .pixelOut(pixelOut), .pixelValid(pixelValid), .pixelReady(pixelReady),
      .sof(sof), .eol(eol), .eof(eof), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int done_due = -10;
   int issued = 0;
   int xfer = 0;
   int rdy_mode = 0;
   int rdy_ph = 0;
   logic [DW-1:0] gmem [256];
   logic [DW-1:0] rmem [256];
   logic [DW-1:0] bmem [256];
   logic [DW-1:0] model_clip = '1;
   int            exp_addr_q[$];
   logic [PW-1:0] exp_pix_q[$];
   logic          prev_stall = 1'b0;
   logic [PW-1:0] prev_out = '0;
   logic          re_s;
   logic [7:0]    a_s;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Plane memories: data valid exactly one cycle after a read strobe.
   always @(posedge clk) begin
      re_s = readEnable;
      a_s  = readAddress[7:0];
      #1;
      if (re_s) begin
         greenRead = gmem[a_s];
         redRead   = rmem[a_s];
         blueRead  = bmem[a_s];
      end else begin
         greenRead = DW'($urandom);
         redRead   = DW'($urandom);
         blueRead  = DW'($urandom);
      end
   end

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0: pixelReady = 1'b1;
         1: begin
            pixelReady = (rdy_ph == 0);
            rdy_ph = (rdy_ph + 1) % 3;
         end
         default: pixelReady = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: compares every read and every transfer against the scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         if (prev_stall) chk("hold_stable", 64'({pixelOut, sof, eol, eof}), 64'(prev_out));
         prev_stall = pixelValid && !pixelReady;
         prev_out   = {pixelOut, sof, eol, eof};
         if (readEnable) begin
            issued++;
            if (exp_addr_q.size() == 0) chk("spurious_read", 1, 0);
            else chk("read_addr", 64'(readAddress), 64'(exp_addr_q.pop_front()));
         end
         if (pixelValid) chk("busy_with_pixel", 64'(busy), 1);
         if (pixelValid && pixelReady) begin
            logic [PW-1:0] e;
            xfer++;
            if (exp_pix_q.size() == 0) chk("spurious_pixel", 1, 0);
            else begin
               e = exp_pix_q.pop_front();
               chk("pixel", 64'({pixelOut, sof, eol, eof}), 64'(e));
               if (e[0]) done_due = cyc + 1;
            end
         end
         if (readEnable) chk("credit_limit", 64'((issued - xfer) <= 2), 1);
         chk("done", 64'(done), 64'(cyc == done_due));
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_planes(input int fill);
      for (int i = 0; i < 256; i++) begin
         if (fill == 0) begin
            gmem[i] = DW'(i);
            rmem[i] = DW'(i + 100);
            bmem[i] = DW'(i + 200);
         end else begin
            gmem[i] = DW'($urandom);
            rmem[i] = DW'($urandom);
            bmem[i] = DW'($urandom);
         end
      end
   endtask

   function automatic logic [DW-1:0] sat(input logic [DW-1:0] v);
      return (v < model_clip) ? v : model_clip;
   endfunction

   // Reference: raster walk, linear address, markers from the frame geometry.
   task automatic model_frame(input int rm, input int cm);
      for (int r = 0; r <= rm; r++) begin
         for (int c = 0; c <= cm; c++) begin
            int a;
            a = r * (cm + 1) + c;
            exp_addr_q.push_back(a);
            exp_pix_q.push_back({sat(rmem[a]), sat(gmem[a]), sat(bmem[a]),
                                 1'(r == 0 && c == 0), 1'(c == cm), 1'(r == rm && c == cm)});
         end
      end
   endtask

   task automatic run_frame(input int rm, input int cm, input int fill, input int mode,
                            input bit poke_busy, input bit poke_done, input logic [DW-1:0] clipv);
      bit valid_frame;
      bit got;
      valid_frame = (rm >= 0) && (cm >= 0);
      rdy_mode = mode;
      fill_planes(fill);
      step();
      start  = 1'b1;
      rowMax = RW'(rm);
      colMax = CW'(cm);
`ifdef CFA_READER_CLIP_EN
      clipMax    = clipv;
      model_clip = clipv;
`else
      model_clip = '1 | clipv;
`endif
      if (valid_frame) model_frame(rm, cm);
      else done_due = cyc + 1;
      step();
      start  = 1'b0;
      rowMax = RW'($urandom);
      colMax = CW'($urandom);
`ifdef CFA_READER_CLIP_EN
      clipMax = DW'($urandom);
`endif
      got = done;
      if (valid_frame) chk("first_read_latency", 64'(readEnable), 1);
      else chk("neg_bound_busy", 64'(busy), 0);
      if (valid_frame && poke_busy) begin
         step();
         start  = 1'b1;
         rowMax = '0;
         colMax = '0;
         step();
         start = 1'b0;
         got = got | done;
      end
      for (int k = 0; k < 600 && !got; k++) begin
         step();
         got = done;
      end
      chk("done_seen", 64'(got), 1);
      if (got && done && poke_done) begin
         start  = 1'b1;
         rowMax = '0;
         colMax = '0;
         step();
         start = 1'b0;
      end
      repeat (3) step();
      chk("scoreboard_pixels_left", 64'(exp_pix_q.size()), 0);
      chk("scoreboard_reads_left", 64'(exp_addr_q.size()), 0);
      chk("idle_busy", 64'(busy), 0);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_pixelValid"}, 64'(pixelValid), 0);
      chk({tag, "_readEnable"}, 64'(readEnable), 0);
      chk({tag, "_readAddress"}, 64'(readAddress), 0);
      chk({tag, "_pixelOut"}, 64'(pixelOut), 0);
      chk({tag, "_markers"}, 64'({sof, eol, eof}), 0);
      chk({tag, "_busy_done"}, 64'({busy, done}), 0);
   endtask

   initial begin
      fill_planes(0);
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b1;
      step();

      run_frame(1, 2, 0, 0, 1'b0, 1'b0, '1);
      run_frame(1, 2, 0, 1, 1'b0, 1'b0, '1);
      run_frame(0, 0, 0, 0, 1'b1, 1'b1, '1);
      run_frame(-1, 2, 0, 0, 1'b0, 1'b0, '1);
      run_frame(2, -1, 0, 1, 1'b0, 1'b0, '1);
      run_frame(0, 4, 1, 2, 1'b0, 1'b1, '1);

      // Mid-frame reset after three pixels of a 4x4 frame.
      rdy_mode = 0;
      fill_planes(0);
      step();
      start  = 1'b1;
      rowMax = 3;
      colMax = 3;
      model_clip = '1;
`ifdef CFA_READER_CLIP_EN
      clipMax = '1;
`endif
      model_frame(3, 3);
      step();
      start = 1'b0;
      begin
         int base;
         base = xfer;
         for (int k = 0; k < 100 && (xfer - base) < 3; k++) step();
         chk("mid_reset_progress", 64'(xfer - base), 3);
      end
      rst = 1'b0;
      #1;
      check_all_zero("mid_reset");
      exp_addr_q.delete();
      exp_pix_q.delete();
      done_due = -10;
      issued = 0;
      xfer = 0;
      step();
      step();
      rst = 1'b1;
      run_frame(3, 3, 0, 0, 1'b0, 1'b0, '1);

`ifdef CFA_READER_CLIP_EN
      run_frame(1, 2, 0, 0, 1'b0, 1'b0, DW'(150));
`endif

      for (int n = 0; n < 30; n++) begin
         int rm, cm;
         rm = ($urandom_range(0, 9) == 0) ? -int'($urandom_range(1, 3)) : int'($urandom_range(0, 5));
         cm = ($urandom_range(0, 9) == 0) ? -int'($urandom_range(1, 3)) : int'($urandom_range(0, 5));
         run_frame(rm, cm, 1, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), DW'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
